// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with a registered result and a valid/ready handshake.
// Logic, add/sub, compares and shifts finish in one cycle. MUL (shift-add,
// LSB first) and DIVU/REMU (restoring division, MSB first) take WIDTH
// iterations.
//
// Handshake: a request is accepted on a rising edge where in_valid & in_ready.
// in_ready is high only in IDLE. out_valid rises on the edge that enters DONE
// and is held until a rising edge with out_ready high. After that edge the
// block returns to IDLE, so the earliest next accept is one cycle later.
module alu_mc #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_A,
    input  logic [WIDTH-1:0] src_B,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_result,
    output logic             zero,
    output logic             busy
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] opa;   // multiplicand (shifts left) / dividend (shifts left)
    logic [WIDTH-1:0] opb;   // multiplier (shifts right) / divisor (fixed)
    logic [WIDTH-1:0] acc;   // product accumulator / partial remainder
    logic [WIDTH-1:0] quo;   // quotient bits, MSB first
    logic [SHW-1:0]   cnt;

    logic [WIDTH-1:0] single_res;
    logic             is_multi;
    logic [SHW-1:0]   shamt;

    // Single-cycle result straight from the request operands, plus the CALC decision.
    always_comb begin
        single_res = '0;
        shamt      = src_B[SHW-1:0];
        is_multi   = (ALU_control == OP_MUL) ||
                     (((ALU_control == OP_DIVU) || (ALU_control == OP_REMU)) && (src_B != '0));
        case (ALU_control)
            OP_AND:  single_res = src_A & src_B;
            OP_OR:   single_res = src_A | src_B;
            OP_ADD:  single_res = src_A + src_B;
            OP_SUB:  single_res = src_A - src_B;
            OP_NOR:  single_res = ~(src_A | src_B);
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(src_A) < $signed(src_B))};
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (src_A < src_B)};
            OP_SLL:  single_res = src_A << shamt;
            OP_SRL:  single_res = src_A >> shamt;
            OP_SRA:  single_res = WIDTH'($signed(src_A) >>> shamt);
            OP_DIVU: single_res = '1;      // only reached with a zero divisor
            OP_REMU: single_res = src_A;   // only reached with a zero divisor
            default: single_res = '0;
        endcase
    end

    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_trial;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] calc_res;

    // One shift-add step and one restoring-division step; op_q picks which is kept.
    always_comb begin
        mul_acc   = opb[0] ? (acc + opa) : acc;
        div_trial = {acc, opa[WIDTH-1]};
        div_diff  = div_trial - {1'b0, opb};
        div_ge    = ~div_diff[WIDTH];
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];
        quo_next  = {quo[WIDTH-2:0], div_ge};
        case (op_q)
            OP_MUL:  calc_res = mul_acc;
            OP_DIVU: calc_res = quo_next;
            default: calc_res = div_rem;
        endcase
    end

    // Control FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ALU_result <= '0;
            zero       <= 1'b1;
            op_q       <= '0;
            opa        <= '0;
            opb        <= '0;
            acc        <= '0;
            quo        <= '0;
            cnt        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= ALU_control;
                        opa      <= src_A;
                        opb      <= src_B;
                        acc      <= '0;
                        quo      <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (is_multi) begin
                            state <= S_CALC;
                        end else begin
                            state      <= S_DONE;
                            out_valid  <= 1'b1;
                            ALU_result <= single_res;
                            zero       <= (single_res == '0);
                        end
                    end
                end
                S_CALC: begin
                    cnt <= cnt + CNT_ONE;
                    opa <= opa << 1;
                    if (op_q == OP_MUL) begin
                        acc <= mul_acc;
                        opb <= opb >> 1;
                    end else begin
                        acc <= div_rem;
                        quo <= quo_next;
                    end
                    if (cnt == CNT_LAST) begin
                        state      <= S_DONE;
                        out_valid  <= 1'b1;
                        ALU_result <= calc_res;
                        zero       <= (calc_res == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed and randomized checks of alu_mc against a plain arithmetic model.
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] src_A;
    logic [W-1:0] src_B;
    logic [3:0]   ALU_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] ALU_result;
    logic         zero;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src_A       (src_A),
        .src_B       (src_B),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALU_result  (ALU_result),
        .zero        (zero),
        .busy        (busy)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the opcode table written as ordinary arithmetic.
    function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned sh;
        sh = b % W;
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a + b;
            4'd6:  return a - b;
            4'd12: return ~(a | b);
            4'd7:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd8:  return (a < b) ? W'(1) : W'(0);
            4'd3:  return a << sh;
            4'd4:  return a >> sh;
            4'd5:  return W'($signed(a) >>> sh);
            4'd9:  return a * b;
            4'd10: return (b == 0) ? {W{1'b1}} : a / b;
            4'd11: return (b == 0) ? a : a % b;
            default: return W'(0);
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [W-1:0] b);
        if (op == 4'd9) return W + 1;
        if ((op == 4'd10 || op == 4'd11) && b != 0) return W + 1;
        return 1;
    endfunction

    // Issue one request, wait for the result, optionally stall the consumer, then release.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int bp);
        int lat;
        int ready_bad;
        int stable_bad;
        logic [W-1:0] exp;
        logic [W-1:0] held_res;
        logic held_zero;
        check({tag, "_in_ready_pre"}, W'(in_ready), W'(1));
        in_valid    = 1'b1;
        ALU_control = op;
        src_A       = a;
        src_B       = b;
        @(posedge clk); #1;
        exp_q.push_back(ref_alu(op, a, b));
        in_valid    = 1'b0;
        src_A       = $urandom;
        src_B       = $urandom;
        ALU_control = 4'($urandom_range(0, 15));
        lat = 1;
        ready_bad = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready || !busy) ready_bad++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, W'(lat), W'(ref_latency(op, b)));
        check({tag, "_in_ready_busy"}, W'(ready_bad), W'(0));
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check({tag, "_result"}, ALU_result, exp);
        check({tag, "_zero"}, W'(zero), W'(exp == 0));
        held_res  = ALU_result;
        held_zero = zero;
        stable_bad = 0;
        for (int i = 0; i < bp; i++) begin
            in_valid = ~in_valid;
            src_A    = $urandom;
            @(posedge clk); #1;
            if (!out_valid || in_ready || ALU_result !== held_res || zero !== held_zero)
                stable_bad++;
        end
        if (bp > 0) check({tag, "_backpressure"}, W'(stable_bad), W'(0));
        // Release with a competing request present; it must not be taken this cycle.
        out_ready   = 1'b1;
        in_valid    = 1'b1;
        ALU_control = 4'd2;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_release_valid"}, W'(out_valid), W'(0));
        check({tag, "_release_ready"}, W'(in_ready), W'(1));
    endtask

    initial begin
        logic [3:0] op_tab[16];
        int v_count;
        logic [W-1:0] rb;
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd12, 4'd7, 4'd8, 4'd3,
                   4'd4, 4'd5, 4'd9, 4'd10, 4'd11, 4'd13, 4'd14, 4'd15};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        src_A       = '0;
        src_B       = '0;
        ALU_control = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_busy", W'(busy), W'(0));
        check("rst_result", ALU_result, W'(0));
        check("rst_zero", W'(zero), W'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases.
        run_op("add_wrap", 4'd2, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sub_neg", 4'd6, 32'd5, 32'd7, 0);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sltu", 4'd8, 32'hFFFF_FFFF, 32'h1, 0);
        run_op("sra", 4'd5, 32'h8000_0000, 32'h24, 0);
        run_op("srl", 4'd4, 32'h8000_0000, 32'h24, 0);
        run_op("mul", 4'd9, 32'h0001_0000, 32'h0001_0001, 0);
        run_op("divu", 4'd10, 32'd100, 32'd7, 0);
        run_op("remu", 4'd11, 32'd100, 32'd7, 0);
        run_op("divu_z", 4'd10, 32'd9, 32'd0, 0);
        run_op("remu_z", 4'd11, 32'd9, 32'd0, 0);
        run_op("undef", 4'd13, 32'h1234, 32'h5678, 0);
        run_op("bp_add", 4'd2, 32'h10, 32'h20, 5);
        run_op("bp_mul", 4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);

        // Reset in the middle of a multiply.
        in_valid    = 1'b1;
        ALU_control = 4'd9;
        src_A       = 32'h1234_5678;
        src_B       = 32'h9ABC_DEF1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_in_ready", W'(in_ready), W'(1));
        check("midrst_busy", W'(busy), W'(0));
        check("midrst_result", ALU_result, W'(0));
        check("midrst_zero", W'(zero), W'(1));
        #2;
        rst_n = 1'b1;
        v_count = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid || !in_ready) v_count++;
        end
        check("midrst_no_stale", W'(v_count), W'(0));

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op("rand", op_tab[$urandom_range(0, 15)], $urandom, rb, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle ALU; successor to the single-cycle combinational ALU.
- Adds a registered result, a valid/ready handshake, signed/unsigned compare, shifts, iterative multiply and unsigned divide/remainder.
- Sits in the execute stage of the multi-cycle RISC-V datapath; the control FSM stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from src_B[SHW-1:0]; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request (state IDLE).
- src_A  in  WIDTH  operand A.
- src_B  in  WIDTH  operand B.
- ALU_control  in  4  opcode, captured on accept.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts the result.
- ALU_result  out  WIDTH  registered result.
- zero  out  1  registered; 1 iff ALU_result == 0.
- busy  out  1  state != IDLE.

Behaviour:
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 1100 NOR.
  - 0111 SLT (signed); 1000 SLTU (unsigned).
  - 0011 SLL; 0100 SRL; 0101 SRA.
  - 1001 MUL (low WIDTH bits of the product); 1010 DIVU; 1011 REMU.
  - Any other code -> result 0.
- Add/sub wrap modulo 2^WIDTH; no overflow flag.
- Reset (async, asserted low):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - ALU_result=0; zero=1; internal counter and accumulators 0.
  - Reset asserted mid-operation aborts it; no result is produced.
- Accept: in_valid & in_ready on a rising edge captures src_A, src_B and ALU_control. Later input changes have no effect.
- FSM:
  - IDLE -> DONE on accept of a single-cycle op (logic/add/sub/compare/shift, divide-by-zero, undefined code).
  - IDLE -> CALC on accept of MUL/DIVU/REMU with a nonzero divisor for DIV/REM.
  - CALC: one iteration per cycle; the counter runs 0..WIDTH-1. At count WIDTH-1 the result is written -> DONE.
  - DONE: out_valid=1. On out_ready -> IDLE, and out_valid drops the next cycle.
- MUL: shift-add, one multiplier bit per cycle, LSB first.
- DIVU/REMU: restoring division, one quotient bit per cycle, MSB first.
- Latency, from the accept edge to the edge that sets out_valid:
  - single-cycle ops: 1 cycle.
  - MUL/DIVU/REMU: WIDTH+1 cycles.
- Divide by zero, in 1 cycle:
  - DIVU -> all ones.
  - REMU -> src_A.
- ALU_result and zero update only on the edge entering DONE. They are stable throughout DONE and keep their values in IDLE until the next result.
- in_ready=0 in CALC and DONE; in_valid is ignored there.
- No back-to-back acceptance in DONE: a new request is accepted in IDLE, at the earliest one cycle after out_ready.
- out_ready is ignored outside DONE.
- A simultaneous in_valid in the DONE->IDLE cycle is not accepted.

Test Plan:
- Reset mid-MUL:
  - Stimulus: pulse rst_n low during CALC, 10 cycles after accept.
  - Required: asynchronously out_valid=0, in_ready=1, ALU_result=0, zero=1; no stale result after release.
- ADD and SUB (WIDTH=32):
  - Stimulus: ADD 0xFFFFFFFF+1.
  - Required: 1 cycle later ALU_result=0, zero=1. SUB 5-7 -> 0xFFFFFFFE, zero=0.
- Compares and shifts:
  - Stimulus: SLT A=0xFFFFFFFF, B=1.
  - Required: result 1; SLTU on the same operands -> 0. SRA 0x80000000 by B=0x24 (amount 4) -> 0xF8000000; SRL on the same operands -> 0x08000000.
- MUL:
  - Stimulus: MUL 0x10000 × 0x10001.
  - Required: out_valid exactly 33 cycles after accept; result 0x00010000 (low bits), zero=0; in_ready=0 throughout.
- DIVU/REMU:
  - Stimulus: DIVU 100/7.
  - Required: 14 after 33 cycles; REMU -> 2. DIVU 9/0 -> 0xFFFFFFFF after 1 cycle; REMU 9/0 -> 9.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and src_A.
  - Required: out_valid, ALU_result and zero remain stable; no new accept. After out_ready=1, the next request is accepted only in IDLE.
